// File: rtl/load_store_unit.sv
// Memory stage: turns LOAD/STORE ops from execute into a req/ready data-memory access,
// returns extended load data to writeback and raises misaligned/illegal/timeout exceptions.
module load_store_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid,
    input  logic [6:0]  ex_opcode,
    input  logic [2:0]  ex_funct3,
    input  logic [31:0] ex_addr,
    input  logic [31:0] ex_wdata,
    input  logic [4:0]  ex_rd,
    output logic        lsu_busy,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        exc_valid,
    output logic [1:0]  exc_code,
    output logic [31:0] exc_addr
);

    localparam logic [6:0]  OP_LOAD  = 7'b0000011;
    localparam logic [6:0]  OP_STORE = 7'b0100011;
    localparam int unsigned CNT_W    = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [31:0]        addr_q;
    logic [2:0]         f3_q;
    logic [4:0]         rd_q;

    logic               is_load, is_store, f3_illegal, misaligned, timeout_hit;
    logic [3:0]         be_c;
    logic [31:0]        wdata_c, lane, load_data;

    assign lsu_busy = (state == BUSY);

    // Decode the op presented by execute: legality, alignment, byte enables, lane replication
    always_comb begin
        is_load    = ex_valid && (ex_opcode == OP_LOAD);
        is_store   = ex_valid && (ex_opcode == OP_STORE);
        f3_illegal = is_load ? ((ex_funct3 == 3'b011) || (ex_funct3[2:1] == 2'b11))
                             : (ex_funct3 >= 3'b011);
        misaligned = 1'b0;
        be_c       = 4'b1111;
        wdata_c    = ex_wdata;
        unique case (ex_funct3[1:0])
            2'b00: begin
                be_c    = 4'b0001 << ex_addr[1:0];
                wdata_c = {4{ex_wdata[7:0]}};
            end
            2'b01: begin
                misaligned = ex_addr[0];
                be_c       = 4'b0011 << ex_addr[1:0];
                wdata_c    = {2{ex_wdata[15:0]}};
            end
            2'b10:   misaligned = |ex_addr[1:0];
            default: misaligned = 1'b0;
        endcase
    end

    // Pick the addressed lane out of the read word and extend it
    always_comb begin
        lane = mem_rdata >> {addr_q[1:0], 3'b000};
        unique case (f3_q)
            3'b000:  load_data = {{24{lane[7]}}, lane[7:0]};
            3'b100:  load_data = {24'd0, lane[7:0]};
            3'b001:  load_data = {{16{lane[15]}}, lane[15:0]};
            3'b101:  load_data = {16'd0, lane[15:0]};
            default: load_data = lane;
        endcase
    end

    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            addr_q    <= '0;
            f3_q      <= '0;
            rd_q      <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_be    <= '0;
            mem_wdata <= '0;
            wb_valid  <= 1'b0;
            wb_rd     <= '0;
            wb_data   <= '0;
            exc_valid <= 1'b0;
            exc_code  <= '0;
            exc_addr  <= '0;
        end else begin
            wb_valid  <= 1'b0;
            exc_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (is_load || is_store) begin
                        if (f3_illegal) begin
                            exc_valid <= 1'b1;
                            exc_code  <= 2'b10;
                            exc_addr  <= ex_addr;
                        end else if (misaligned) begin
                            exc_valid <= 1'b1;
                            exc_code  <= 2'b01;
                            exc_addr  <= ex_addr;
                        end else begin
                            state     <= BUSY;
                            cnt       <= '0;
                            mem_req   <= 1'b1;
                            mem_we    <= is_store;
                            mem_addr  <= {ex_addr[31:2], 2'b00};
                            mem_be    <= be_c;
                            mem_wdata <= wdata_c;
                            addr_q    <= ex_addr;
                            f3_q      <= ex_funct3;
                            rd_q      <= ex_rd;
                        end
                    end
                end
                BUSY: begin
                    // A handshake in the timeout cycle still completes normally
                    if (mem_ready) begin
                        state   <= IDLE;
                        mem_req <= 1'b0;
                        if (!mem_we) begin
                            wb_valid <= (rd_q != 5'd0);
                            wb_rd    <= rd_q;
                            wb_data  <= load_data;
                        end
                    end else if (timeout_hit) begin
                        state     <= IDLE;
                        mem_req   <= 1'b0;
                        exc_valid <= 1'b1;
                        exc_code  <= 2'b11;
                        exc_addr  <= addr_q;
                    end else if (TIMEOUT_CYCLES != 0) begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
